gb_cpu_bus_responder: RTL and testbench
=======================================

Name: gb_cpu_bus_responder

Overview:
- Memory-side responder for the GameBoy CPU external bus (MREQ_n/RD_n/WR_n/A/DO/DI/WAIT_n).
- Edge-detects CPU read/write strobes and forwards each access as one request on a req/ack backend port (SDRAM arbiter, cart mapper).
- Stretches the CPU with WAIT_n until the backend acknowledges, and returns read data on DI.
- Sits between the CPU wrapper and the system memory arbiter in the top-level GameBoy core.

Parameters:
- ACK_TIMEOUT, 255: max cycles to wait for mem_ack before abandoning an access; 0 disables the timeout.
- POSTED_WRITE, 0: 1 => a write releases WAIT_n immediately, using a single-entry write buffer; 0 => writes stall like reads.
- TO_WIDTH, 8: width of the timeout counter; must satisfy 2^TO_WIDTH > ACK_TIMEOUT.

Ports:
- CLK_n  in  1  system clock; all logic on rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- cpu_a  in  16  CPU address.
- cpu_do  in  8  CPU write data.
- cpu_mreq_n  in  1  memory request strobe, active low.
- cpu_rd_n  in  1  read strobe, active low.
- cpu_wr_n  in  1  write strobe, active low.
- cpu_di  out  8  read data to CPU; registered.
- cpu_wait_n  out  1  CPU wait, low = stall; registered.
- mem_req  out  1  backend request level; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  16  latched address.
- mem_wdata  out  8  latched write data.
- mem_rdata  in  8  backend read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- timeout_err  out  1  one-cycle pulse when an access times out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, immediate): cpu_di=8'hFF, cpu_wait_n=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout_err=0, state=IDLE, rd_prev=1, wr_prev=1, timeout counter=0.
- Strobes are sampled every rising edge into rd_prev/wr_prev.
  - rd_start = !cpu_rd_n && rd_prev && !cpu_mreq_n.
  - wr_start = !cpu_wr_n && wr_prev && !cpu_mreq_n.
  - Accesses with cpu_mreq_n high are ignored.
  - If rd_start and wr_start occur in the same cycle, the write takes priority and the read is dropped.
- States: IDLE, REQ, HOLD, plus WBUF when POSTED_WRITE=1.
- IDLE, on rd_start or wr_start (same edge):
  - mem_addr<=cpu_a; mem_wdata<=cpu_do if write; mem_we<=wr_start; mem_req<=1; counter<=0.
  - Non-posted: cpu_wait_n<=0 and go to REQ.
  - Posted write: cpu_wait_n stays 1 and go to WBUF.
  - Request appears one cycle after the strobe edge is sampled.
- REQ:
  - mem_req held; counter increments each cycle.
  - On mem_ack: mem_req<=0; cpu_wait_n<=1; for a read, cpu_di<=mem_rdata on the same edge; go to HOLD.
  - Minimum read latency, strobe sample to cpu_wait_n high, is 2 cycles with a 1-cycle ack.
- Timeout (ACK_TIMEOUT>0): when the counter reaches ACK_TIMEOUT without mem_ack:
  - mem_req<=0; cpu_wait_n<=1; cpu_di<=8'hFF for a read; timeout_err pulses for 1 cycle; go to HOLD.
  - A mem_ack on that exact edge takes precedence: normal completion, no error.
- HOLD: remain until cpu_rd_n and cpu_wr_n are both high, then IDLE. This prevents retriggering on strobes held across T2/T3 and wait stretching.
- WBUF (posted write in flight):
  - From the WBUF entry edge, WBUF goes directly to IDLE on ack/timeout. HOLD is skipped because the CPU was not stalled.
  - A new rd_start/wr_start arriving while in WBUF drives cpu_wait_n<=0. It is recorded as pending, with cpu_a/cpu_do captured into a shadow register.
  - On the current ack, the pending access is issued on the next edge, entering REQ (a pending read/write is not posted).
  - Only one pending access is possible.
- mem_ack when mem_req=0 is ignored.
- cpu_di holds its last value between reads. Writes never modify cpu_di.
- busy = (state != IDLE), registered.
- Reset during REQ or WBUF drops mem_req immediately. The backend must tolerate a withdrawn request, and a later stray ack is ignored.

Test Plan:
- Read, ack after 3 cycles: A=16'h0150, mem_rdata=8'h3E. Required: mem_req rises 1 cycle after RD_n edge sample; cpu_wait_n low for 4 cycles; cpu_di=8'h3E on the edge cpu_wait_n rises; one request only.
- Write, POSTED_WRITE=0: A=16'hC000, DO=8'hA5, ack after 1 cycle. Required: mem_we=1, mem_addr=C000, mem_wdata=A5; cpu_wait_n low 2 cycles; cpu_di unchanged.
- Strobe held 6 cycles after ack. Required: state HOLD, no second mem_req; returns to IDLE 1 cycle after RD_n rises.
- Timeout, ACK_TIMEOUT=4, no ack. Required: after 4 REQ cycles, timeout_err pulses once, cpu_di=FF, cpu_wait_n=1; ack on the timeout edge instead gives normal completion with no error.
- POSTED_WRITE=1: write FF40<=91 with ack delayed 5 cycles, then a read of 8000 issued 2 cycles later. Required: cpu_wait_n=1 through the write; low from the read; read issued the cycle after the write ack, addr 8000.
- Reset asserted mid-REQ. Required: mem_req=0, cpu_wait_n=1, cpu_di=FF asynchronously; a subsequent ack causes no state change.

Source files
------------

// File: rtl/gb_cpu_bus_responder_if.sv
// Bus bundle between the GameBoy CPU wrapper, the bus responder and the
// memory backend (SDRAM arbiter / cart mapper).
//   CPU side : cpu_a, cpu_do, cpu_mreq_n, cpu_rd_n, cpu_wr_n -> responder
//              cpu_di, cpu_wait_n                            <- responder
//   Backend  : mem_req, mem_we, mem_addr, mem_wdata           <- responder
//              mem_rdata, mem_ack                             -> responder
//   Status   : timeout_err, busy                              <- responder
// slave  = the responder itself; master = the surrounding environment.
interface gb_cpu_bus_responder_if;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        timeout_err;
  logic        busy;

  modport slave (
    input  cpu_a, cpu_do, cpu_mreq_n, cpu_rd_n, cpu_wr_n, mem_rdata, mem_ack,
    output cpu_di, cpu_wait_n, mem_req, mem_we, mem_addr, mem_wdata,
           timeout_err, busy
  );

  modport master (
    output cpu_a, cpu_do, cpu_mreq_n, cpu_rd_n, cpu_wr_n, mem_rdata, mem_ack,
    input  cpu_di, cpu_wait_n, mem_req, mem_we, mem_addr, mem_wdata,
           timeout_err, busy
  );
endinterface

// File: rtl/gb_cpu_bus_responder.sv
// Memory-side responder for the GameBoy CPU external bus. Each falling
// RD_n/WR_n edge (with MREQ_n low) becomes one req/ack transaction on the
// backend; the CPU is stretched with WAIT_n until the backend acknowledges
// or the access times out. Optional single-entry posted write buffer.
// Ports:
//   CLK_n   - system clock, rising edge
//   RESET_n - asynchronous active-low reset
//   bus     - gb_cpu_bus_responder_if.slave (CPU, backend and status signals)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a fresh read/write strobe edge
// REQ   | request outstanding, CPU stalled, timeout counter running
// HOLD  | access done, waiting for both strobes to return high
// WBUF  | posted write outstanding, CPU free; may hold one pending access
module gb_cpu_bus_responder #(
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter bit          POSTED_WRITE = 1'b0,
  parameter int unsigned TO_WIDTH     = 8
) (
  input  logic                    CLK_n,
  input  logic                    RESET_n,
  gb_cpu_bus_responder_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD, ST_WBUF} state_e;

  state_e              state_q, state_d;
  logic                rd_prev_q, wr_prev_q;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]          di_q, di_d;
  logic                wait_n_q, wait_n_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [15:0]         addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                terr_q, terr_d;
  logic                busy_q;
  logic                pend_q, pend_d;
  logic                pend_we_q, pend_we_d;
  logic [15:0]         pend_addr_q, pend_addr_d;
  logic [7:0]          pend_wdata_q, pend_wdata_d;

  logic                rd_start, wr_start, start;
  logic [TO_WIDTH-1:0] cnt_inc;
  logic                timed_out;

  assign rd_start  = !bus.cpu_rd_n && rd_prev_q && !bus.cpu_mreq_n;
  assign wr_start  = !bus.cpu_wr_n && wr_prev_q && !bus.cpu_mreq_n;
  assign start     = rd_start | wr_start;
  assign cnt_inc   = cnt_q + 1'b1;
  // Fires on the edge the counter would reach ACK_TIMEOUT.
  assign timed_out = (ACK_TIMEOUT != 0) && (cnt_inc == TO_WIDTH'(ACK_TIMEOUT));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    di_d         = di_q;
    wait_n_d     = wait_n_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    terr_d       = 1'b0;
    pend_d       = pend_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d = bus.cpu_a;
          if (wr_start) wdata_d = bus.cpu_do;
          we_d   = wr_start;
          req_d  = 1'b1;
          cnt_d  = '0;
          if (POSTED_WRITE && wr_start) begin
            state_d = ST_WBUF;
          end else begin
            wait_n_d = 1'b0;
            state_d  = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        cnt_d = cnt_inc;
        if (bus.mem_ack) begin
          req_d    = 1'b0;
          wait_n_d = 1'b1;
          if (!we_q) di_d = bus.mem_rdata;
          state_d  = ST_HOLD;
        end else if (timed_out) begin
          req_d    = 1'b0;
          wait_n_d = 1'b1;
          if (!we_q) di_d = 8'hFF;
          terr_d   = 1'b1;
          state_d  = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (bus.cpu_rd_n && bus.cpu_wr_n) state_d = ST_IDLE;
      end

      ST_WBUF: begin
        cnt_d = cnt_inc;
        if (start && !pend_q) begin
          pend_d       = 1'b1;
          pend_we_d    = wr_start;
          pend_addr_d  = bus.cpu_a;
          pend_wdata_d = bus.cpu_do;
          wait_n_d     = 1'b0;
        end
        if (bus.mem_ack || timed_out) begin
          terr_d = !bus.mem_ack;
          // A pending access (including one arriving on this edge) is
          // issued straight away; mem_req stays high with the new address.
          if (pend_d) begin
            addr_d  = pend_addr_d;
            we_d    = pend_we_d;
            if (pend_we_d) wdata_d = pend_wdata_d;
            req_d   = 1'b1;
            cnt_d   = '0;
            pend_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= ST_IDLE;
      rd_prev_q    <= 1'b1;
      wr_prev_q    <= 1'b1;
      cnt_q        <= '0;
      di_q         <= 8'hFF;
      wait_n_q     <= 1'b1;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      terr_q       <= 1'b0;
      busy_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_prev_q    <= bus.cpu_rd_n;
      wr_prev_q    <= bus.cpu_wr_n;
      cnt_q        <= cnt_d;
      di_q         <= di_d;
      wait_n_q     <= wait_n_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      terr_q       <= terr_d;
      busy_q       <= (state_d != ST_IDLE);
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
    end
  end

  assign bus.cpu_di      = di_q;
  assign bus.cpu_wait_n  = wait_n_q;
  assign bus.mem_req     = req_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.timeout_err = terr_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_gb_cpu_bus_responder.sv
// Bench for gb_cpu_bus_responder: a non-posted instance (ACK_TIMEOUT=4) and a
// posted-write instance (ACK_TIMEOUT=8) share the stimulus; sel picks the one
// whose outputs are checked. Expected outputs come from per-access timelines
// computed from the access parameters (ack delay, timeout, hold length).
module tb_gb_cpu_bus_responder;
  logic CLK_n   = 1'b0;
  logic RESET_n = 1'b1;
  always #5 CLK_n = ~CLK_n;

  logic [15:0] a;
  logic [7:0]  dout, rdata;
  logic        mreq_n, rd_n, wr_n, ack;
  logic        sel;

  gb_cpu_bus_responder_if ifn();
  gb_cpu_bus_responder_if ifp();

  assign ifn.cpu_a = a;      assign ifp.cpu_a = a;
  assign ifn.cpu_do = dout;  assign ifp.cpu_do = dout;
  assign ifn.cpu_mreq_n = mreq_n; assign ifp.cpu_mreq_n = mreq_n;
  assign ifn.cpu_rd_n = rd_n; assign ifp.cpu_rd_n = rd_n;
  assign ifn.cpu_wr_n = wr_n; assign ifp.cpu_wr_n = wr_n;
  assign ifn.mem_rdata = rdata; assign ifp.mem_rdata = rdata;
  assign ifn.mem_ack = ack;  assign ifp.mem_ack = ack;

  gb_cpu_bus_responder #(.ACK_TIMEOUT(4), .POSTED_WRITE(1'b0), .TO_WIDTH(3))
    dut_np (.CLK_n(CLK_n), .RESET_n(RESET_n), .bus(ifn));
  gb_cpu_bus_responder #(.ACK_TIMEOUT(8), .POSTED_WRITE(1'b1), .TO_WIDTH(4))
    dut_p  (.CLK_n(CLK_n), .RESET_n(RESET_n), .bus(ifp));

  logic [7:0]  o_di, o_wdata;
  logic [15:0] o_addr;
  logic        o_wait, o_req, o_we, o_terr, o_busy;
  assign o_di    = sel ? ifp.cpu_di      : ifn.cpu_di;
  assign o_wait  = sel ? ifp.cpu_wait_n  : ifn.cpu_wait_n;
  assign o_req   = sel ? ifp.mem_req     : ifn.mem_req;
  assign o_we    = sel ? ifp.mem_we      : ifn.mem_we;
  assign o_addr  = sel ? ifp.mem_addr    : ifn.mem_addr;
  assign o_wdata = sel ? ifp.mem_wdata   : ifn.mem_wdata;
  assign o_terr  = sel ? ifp.timeout_err : ifn.timeout_err;
  assign o_busy  = sel ? ifp.busy        : ifn.busy;

  int errors = 0;
  int checks = 0;
  int n_wait_low = 0, n_req_rise = 0, n_terr = 0;
  bit chk_en = 1'b0;
  int cur_T = 4;
  logic [7:0]  cur_di = 8'hFF;
  logic        exp_req, exp_we, exp_wait, exp_busy, exp_terr;
  logic [15:0] exp_addr;
  logic [7:0]  exp_wdata, exp_di;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic prev_req = 1'b0;
    forever begin
      @(negedge CLK_n);
      if (chk_en) begin
        check("cpu_wait_n", 32'(o_wait), 32'(exp_wait));
        check("mem_req", 32'(o_req), 32'(exp_req));
        check("busy", 32'(o_busy), 32'(exp_busy));
        check("timeout_err", 32'(o_terr), 32'(exp_terr));
        check("cpu_di", 32'(o_di), 32'(exp_di));
        if (exp_req) begin
          check("mem_we", 32'(o_we), 32'(exp_we));
          check("mem_addr", 32'(o_addr), 32'(exp_addr));
          if (exp_we) check("mem_wdata", 32'(o_wdata), 32'(exp_wdata));
        end
      end
      if (!o_wait) n_wait_low++;
      if (o_req && !prev_req) n_req_rise++;
      if (o_terr) n_terr++;
      prev_req = o_req;
    end
  endtask

  task automatic set_idle();
    exp_req = 1'b0; exp_wait = 1'b1; exp_busy = 1'b0; exp_terr = 1'b0; exp_di = cur_di;
  endtask

  task automatic quiet();
    rd_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1; ack = 1'b0;
    a = 16'($urandom); dout = 8'($urandom); rdata = 8'($urandom);
  endtask

  // One CPU access that stalls (or is ignored when ghost: MREQ_n high).
  // d: ack is sampled on the d-th edge after the strobe sample edge.
  // h: extra cycles the strobe stays low after completion.
  task automatic np_access(input bit we, input bit both, input bit ghost,
                           input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] rd, input int d, input int h);
    bit to, low, isw;
    int c, kend;
    logic [7:0] di_after;
    isw      = we | both;
    to       = (cur_T != 0) && (d > cur_T);
    c        = to ? cur_T : d;
    kend     = ghost ? ((h + 2 > d) ? h + 2 : d) : ((c + h + 1 > d) ? c + h + 1 : d);
    di_after = (ghost || isw) ? cur_di : (to ? 8'hFF : rd);
    @(posedge CLK_n); #1;
    a = addr; dout = wd; ack = 1'b0; rdata = 8'($urandom);
    rd_n = !(!we || both); wr_n = !isw; mreq_n = ghost;
    for (int k = 0; k <= kend; k++) begin
      @(posedge CLK_n); #1;
      if (ghost) set_idle();
      else if (k < c) begin
        exp_req = 1'b1; exp_we = isw; exp_addr = addr; exp_wdata = wd;
        exp_wait = 1'b0; exp_busy = 1'b1; exp_terr = 1'b0; exp_di = cur_di;
      end else begin
        exp_req = 1'b0; exp_wait = 1'b1; exp_terr = (k == c) && to;
        exp_di = di_after; exp_busy = (k <= c + h);
      end
      low    = ghost ? (k + 1 <= h) : (k + 1 <= c + h);
      rd_n   = !(low && (!we || both));
      wr_n   = !(low && isw);
      mreq_n = !low || ghost;
      ack    = (k + 1 == d);
      rdata  = (k + 1 == d) ? rd : 8'($urandom);
    end
    cur_di = di_after;
  endtask

  // Posted write (1-cycle strobe) acked after dw cycles; optionally a second
  // access sampled at edge s (2..dw) that becomes pending, then acked d2d
  // cycles after it is issued.
  task automatic posted_pair(input bit present, input bit we2,
                             input logic [15:0] a1, input logic [7:0] d1,
                             input logic [15:0] a2, input logic [7:0] d2,
                             input logic [7:0] r2, input int dw, input int s,
                             input int d2d, input int h);
    int e2, kend;
    bit low2;
    logic [7:0] di_after;
    e2       = dw + d2d;
    kend     = present ? e2 + h + 1 : dw + 1;
    di_after = (present && !we2) ? r2 : cur_di;
    @(posedge CLK_n); #1;
    a = a1; dout = d1; wr_n = 1'b0; rd_n = 1'b1; mreq_n = 1'b0; ack = 1'b0;
    for (int k = 0; k <= kend; k++) begin
      @(posedge CLK_n); #1;
      if (k < dw) begin
        exp_req = 1'b1; exp_we = 1'b1; exp_addr = a1; exp_wdata = d1;
        exp_wait = !(present && k >= s); exp_busy = 1'b1;
      end else if (!present) begin
        exp_req = 1'b0; exp_wait = 1'b1; exp_busy = 1'b0;
      end else if (k < e2) begin
        exp_req = 1'b1; exp_we = we2; exp_addr = a2; exp_wdata = d2;
        exp_wait = 1'b0; exp_busy = 1'b1;
      end else begin
        exp_req = 1'b0; exp_wait = 1'b1; exp_busy = (k <= e2 + h);
      end
      exp_terr = 1'b0;
      exp_di   = (present && k >= e2) ? di_after : cur_di;
      if (k == 0) begin a = a2; dout = d2; end
      low2   = present && (k + 1 >= s) && (k + 1 <= e2 + h);
      wr_n   = !(low2 && we2);
      rd_n   = !(low2 && !we2);
      mreq_n = !low2;
      ack    = (k + 1 == dw) || (present && (k + 1 == e2));
      rdata  = (present && !we2 && (k + 1 == e2)) ? r2 : 8'($urandom);
    end
    cur_di = di_after;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_di"},    32'(o_di),    32'h0000_00FF);
    check({tag, "_wait"},  32'(o_wait),  32'd1);
    check({tag, "_req"},   32'(o_req),   32'd0);
    check({tag, "_we"},    32'(o_we),    32'd0);
    check({tag, "_addr"},  32'(o_addr),  32'd0);
    check({tag, "_wdata"}, 32'(o_wdata), 32'd0);
    check({tag, "_terr"},  32'(o_terr),  32'd0);
    check({tag, "_busy"},  32'(o_busy),  32'd0);
  endtask

  initial begin
    int w0, r0, t0;
    fork compare_loop(); join_none
    sel = 1'b0;
    quiet();
    #1 RESET_n = 1'b0;
    #2 check_reset_vals("reset_np");
    repeat (2) @(posedge CLK_n);
    #1 RESET_n = 1'b1;
    cur_di = 8'hFF; set_idle(); chk_en = 1'b1;

    // Read 0150, ack on 4th edge: 4 stall cycles, one request.
    w0 = n_wait_low; r0 = n_req_rise;
    np_access(1'b0, 1'b0, 1'b0, 16'h0150, 8'h00, 8'h3E, 4, 0);
    check("rd_di_3E", 32'(o_di), 32'h3E);
    check("rd_wait_cycles", n_wait_low - w0, 4);
    check("rd_one_req", n_req_rise - r0, 1);

    // Non-posted write C000<=A5: 2 stall cycles, cpu_di untouched.
    w0 = n_wait_low;
    np_access(1'b1, 1'b0, 1'b0, 16'hC000, 8'hA5, 8'h77, 2, 1);
    check("wr_wait_cycles", n_wait_low - w0, 2);
    check("wr_di_kept", 32'(o_di), 32'h3E);

    // Strobe held 6 cycles after ack: still only one request.
    r0 = n_req_rise;
    np_access(1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'h12, 1, 6);
    check("hold_one_req", n_req_rise - r0, 1);

    // Timeout: no ack within 4 REQ cycles (stray ack later is ignored).
    t0 = n_terr; w0 = n_wait_low;
    np_access(1'b0, 1'b0, 1'b0, 16'h2345, 8'h00, 8'h66, 7, 0);
    check("to_one_pulse", n_terr - t0, 1);
    check("to_di_FF", 32'(o_di), 32'hFF);
    check("to_wait_cycles", n_wait_low - w0, 4);

    // Ack on the timeout edge wins.
    t0 = n_terr;
    np_access(1'b0, 1'b0, 1'b0, 16'h2346, 8'h00, 8'h5A, 4, 0);
    check("to_edge_no_err", n_terr - t0, 0);
    check("to_edge_di", 32'(o_di), 32'h5A);

    // Both strobes together (write wins) and an MREQ_n-high access.
    np_access(1'b0, 1'b1, 1'b0, 16'h9000, 8'hC3, 8'h11, 2, 0);
    r0 = n_req_rise;
    np_access(1'b0, 1'b0, 1'b1, 16'h9001, 8'h00, 8'h22, 2, 1);
    check("ghost_no_req", n_req_rise - r0, 0);

    for (int i = 0; i < 40; i++)
      np_access(1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                16'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(1, 7), $urandom_range(0, 3));

    // Reset in the middle of a REQ phase.
    chk_en = 1'b0;
    @(posedge CLK_n); #1;
    a = 16'h1234; rd_n = 1'b0; mreq_n = 1'b0;
    @(posedge CLK_n); #1;
    check("pre_rst_req", 32'(o_req), 32'd1);
    @(posedge CLK_n); #3;
    RESET_n = 1'b0;
    #1 check("rst_req", 32'(o_req), 32'd0);
    check("rst_wait", 32'(o_wait), 32'd1);
    check("rst_di", 32'(o_di), 32'hFF);
    check("rst_busy", 32'(o_busy), 32'd0);
    @(posedge CLK_n); #1;
    RESET_n = 1'b1; rd_n = 1'b1; mreq_n = 1'b1; ack = 1'b1;
    @(posedge CLK_n); #1;
    ack = 1'b0;
    @(posedge CLK_n); #1;
    check("stray_req", 32'(o_req), 32'd0);
    check("stray_busy", 32'(o_busy), 32'd0);
    check("stray_wait", 32'(o_wait), 32'd1);
    cur_di = 8'hFF; set_idle(); chk_en = 1'b1;

    // Posted-write instance.
    sel = 1'b1; cur_T = 8;
    check_reset_vals("idle_p");
    set_idle();

    // Write FF40<=91 acked after 5 cycles; read 8000 starts 2 cycles in.
    w0 = n_wait_low; r0 = n_req_rise;
    posted_pair(1'b1, 1'b0, 16'hFF40, 8'h91, 16'h8000, 8'h00, 8'hB7, 5, 2, 1, 0);
    check("pw_wait_cycles", n_wait_low - w0, 4);
    check("pw_req_rises", n_req_rise - r0, 1);
    check("pw_rd_di", 32'(o_di), 32'hB7);

    w0 = n_wait_low;
    posted_pair(1'b0, 1'b0, 16'hFF41, 8'h3C, 16'h0000, 8'h00, 8'h00, 3, 2, 1, 0);
    check("pw_alone_no_stall", n_wait_low - w0, 0);

    for (int i = 0; i < 40; i++) begin
      int dw;
      dw = $urandom_range(2, 6);
      if ($urandom_range(0, 3) == 0)
        np_access(1'b0, 1'b0, ($urandom_range(0, 5) == 0), 16'($urandom), 8'($urandom),
                  8'($urandom), $urandom_range(1, 10), $urandom_range(0, 3));
      else
        posted_pair(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                    16'($urandom), 8'($urandom), 8'($urandom),
                    dw, $urandom_range(2, dw), $urandom_range(1, 6), $urandom_range(0, 3));
    end

    @(posedge CLK_n); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
